mem_responder: RTL and testbench

Responder-side memory for the 8-bit accumulator CPU family: a 32×8 storage array behind a req/ack handshake with a configurable number of wait states. It serves one read or write per handshake, flags initiators that abandon a request, and keeps wrapping access counters for debug. It sits on the data/instruction address bus as the target of the CPU's memory initiator. It lets the CPU side be verified against slow memory.

---
 rtl/typedefs.sv | 13 +
 rtl/mem_responder_if.sv | 31 +++
 rtl/wait_counter.sv | 30 +++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/typedefs.sv
// Shared types for the accumulator-CPU memory responder.
// State encoding and wait-counter width.
package typedefs;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } memRespStateT;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_responder_if.sv
// req/ack memory bus between the CPU initiator and the responder.
// Debug counters travel with the bus for convenience.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  err;
  logic [7:0]            rd_count;
  logic [7:0]            wr_count;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, busy, err,
    input  rd_count, wr_count
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, busy, err,
    output rd_count, wr_count
  );

endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter with a zero flag.
// Sized for up to 15 inserted wait states.
module wait_counter
  import typedefs::*;
#(
  parameter int W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// 32x8 responder memory behind a req/ack handshake.
// Inserts WAIT_STATES wait cycles and flags abandoned requests.
module mem_responder
  import typedefs::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [WAIT_CNT_W-1:0] LOAD_VAL =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  memRespStateT state;
  memRespStateT nextState;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  weQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0] wdataQ;
  logic [DATA_WIDTH-1:0] rdataQ;
  logic                  errQ;
  logic [7:0]            rdCnt;
  logic [7:0]            wrCnt;

  logic                  capture;
  logic                  abort;
  logic                  load;
  logic                  dec;
  logic                  zero;
  logic                  enterAck;
  logic                  accWe;
  logic [ADDR_WIDTH-1:0] accAddr;

  wait_counter u_waitCnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .loadVal (LOAD_VAL),
    .dec     (dec),
    .zero    (zero)
  );

  always_comb begin
    nextState = state;
    capture   = 1'b0;
    abort     = 1'b0;
    load      = 1'b0;
    dec       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          capture   = 1'b1;
          load      = 1'b1;
          nextState = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        // A dropped req wins even when the count has expired.
        if (!bus.req) begin
          abort     = 1'b1;
          nextState = IDLE;
        end else if (zero) begin
          nextState = ACK;
        end else begin
          dec = 1'b1;
        end
      end
      ACK: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // With zero wait states the capture and ACK entry share an edge.
  assign enterAck = (nextState == ACK) && (state != ACK);
  assign accWe    = capture ? bus.we   : weQ;
  assign accAddr  = capture ? bus.addr : addrQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
      rdCnt  <= '0;
      wrCnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= nextState;
      errQ  <= abort;
      if (capture) begin
        weQ    <= bus.we;
        addrQ  <= bus.addr;
        wdataQ <= bus.wdata;
      end
      if (enterAck && !accWe) begin
        rdataQ <= mem[accAddr];
      end
      if (state == ACK) begin
        if (weQ) begin
          mem[addrQ] <= wdataQ;
          wrCnt      <= wrCnt + 1'b1;
        end else begin
          rdCnt <= rdCnt + 1'b1;
        end
      end
    end
  end

  assign bus.ack      = (state == ACK);
  assign bus.busy     = (state != IDLE);
  assign bus.err      = errQ;
  assign bus.rdata    = rdataQ;
  assign bus.rd_count = rdCnt;
  assign bus.wr_count = wrCnt;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// Covers default wait states and a zero-wait instance.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) b2 ();
  mem_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) b0 ();

  mem_responder #(
    .ADDR_WIDTH  (5),
    .DATA_WIDTH  (8),
    .WAIT_STATES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  mem_responder #(
    .ADDR_WIDTH  (5),
    .DATA_WIDTH  (8),
    .WAIT_STATES (0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] expRdata;
    logic [7:0] expRd;
    logic [7:0] expWr;
  } vecT;

  vecT vecs[7];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input bit sel, input bit r, input bit w,
                        input logic [4:0] a, input logic [7:0] d);
    if (sel) begin
      b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
    end
  endtask

  // sel=1 targets the zero-wait instance.
  task automatic txn(input bit sel, input bit w, input logic [4:0] a,
                     input logic [7:0] d, output int lat,
                     output logic [7:0] rd);
    logic ackNow;
    setReq(sel, 1'b1, w, a, d);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      ackNow = sel ? b0.ack : b2.ack;
      if (ackNow === 1'b1) begin
        lat = n;
        break;
      end
    end
    rd = sel ? b0.rdata : b2.rdata;
    if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    setReq(sel, 1'b0, w, a, d);
    step();
  endtask

  int lat;
  logic [7:0] rd;
  int ackT[3];
  logic [7:0] ackD[3];
  int k;
  int badLat;

  initial begin
    vecs[0] = '{1'b0, 5'd5, 8'h00, 8'h00, 8'd1, 8'd0};
    vecs[1] = '{1'b1, 5'd3, 8'hA5, 8'h00, 8'd1, 8'd1};
    vecs[2] = '{1'b0, 5'd3, 8'h00, 8'hA5, 8'd2, 8'd1};
    vecs[3] = '{1'b1, 5'd0, 8'h11, 8'hA5, 8'd2, 8'd2};
    vecs[4] = '{1'b1, 5'd1, 8'h22, 8'hA5, 8'd2, 8'd3};
    vecs[5] = '{1'b1, 5'd2, 8'h33, 8'hA5, 8'd2, 8'd4};
    vecs[6] = '{1'b0, 5'd1, 8'h00, 8'h22, 8'd3, 8'd4};

    setReq(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    setReq(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    rst = 1'b1;
    step();
    step();
    chk("rst_ack", {31'd0, b2.ack}, 32'd0);
    chk("rst_busy", {31'd0, b2.busy}, 32'd0);
    chk("rst_err", {31'd0, b2.err}, 32'd0);
    chk("rst_rdata", {24'd0, b2.rdata}, 32'd0);
    chk("rst_rdcnt", {24'd0, b2.rd_count}, 32'd0);
    chk("rst_wrcnt", {24'd0, b2.wr_count}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
      chk($sformatf("vec%0d_lat", i), lat, 32'd3);
      chk($sformatf("vec%0d_rdata", i), {24'd0, rd},
          {24'd0, vecs[i].expRdata});
      chk($sformatf("vec%0d_rdcnt", i), {24'd0, b2.rd_count},
          {24'd0, vecs[i].expRd});
      chk($sformatf("vec%0d_wrcnt", i), {24'd0, b2.wr_count},
          {24'd0, vecs[i].expWr});
      chk($sformatf("vec%0d_busy", i), {31'd0, b2.busy}, 32'd0);
    end

    // Back-to-back reads with req held high.
    k = 0;
    setReq(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
    for (int t = 1; t <= 40 && k < 3; t++) begin
      step();
      if (b2.ack === 1'b1) begin
        ackT[k] = t;
        ackD[k] = b2.rdata;
        k++;
        if (k == 3) b2.req = 1'b0;
        else b2.addr = 5'(k);
      end
    end
    step();
    chk("b2b_acks", k, 32'd3);
    chk("b2b_first", ackT[0], 32'd3);
    chk("b2b_gap1", ackT[1] - ackT[0], 32'd4);
    chk("b2b_gap2", ackT[2] - ackT[1], 32'd4);
    chk("b2b_d0", {24'd0, ackD[0]}, 32'h11);
    chk("b2b_d1", {24'd0, ackD[1]}, 32'h22);
    chk("b2b_d2", {24'd0, ackD[2]}, 32'h33);
    chk("b2b_rdcnt", {24'd0, b2.rd_count}, 32'd6);

    // Abort on the edge where the wait counter has reached zero.
    setReq(1'b0, 1'b1, 1'b1, 5'd7, 8'h3C);
    step();
    step();
    b2.req = 1'b0;
    step();
    chk("abort_err", {31'd0, b2.err}, 32'd1);
    chk("abort_ack", {31'd0, b2.ack}, 32'd0);
    chk("abort_busy", {31'd0, b2.busy}, 32'd0);
    txn(1'b0, 1'b0, 5'd7, 8'h00, lat, rd);
    chk("abort_read7", {24'd0, rd}, 32'h00);
    chk("abort_lat", lat, 32'd3);
    chk("abort_err_gone", {31'd0, b2.err}, 32'd0);
    chk("abort_wrcnt", {24'd0, b2.wr_count}, 32'd4);
    chk("abort_rdcnt", {24'd0, b2.rd_count}, 32'd7);

    // Reset during WAIT of a write.
    setReq(1'b0, 1'b1, 1'b1, 5'd9, 8'hFF);
    step();
    chk("mid_busy", {31'd0, b2.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    b2.req = 1'b0;
    chk("mid_ack", {31'd0, b2.ack}, 32'd0);
    chk("mid_busy0", {31'd0, b2.busy}, 32'd0);
    k = 0;
    for (int t = 0; t < 5; t++) begin
      step();
      if (b2.ack === 1'b1) k++;
    end
    chk("mid_noack", k, 32'd0);
    txn(1'b0, 1'b0, 5'd9, 8'h00, lat, rd);
    chk("mid_read9", {24'd0, rd}, 32'h00);
    chk("mid_wrcnt", {24'd0, b2.wr_count}, 32'd0);
    chk("mid_read3", {24'd0, b2.rd_count}, 32'd1);

    // Write counter wrap.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    badLat = 0;
    for (int i = 0; i < 256; i++) begin
      txn(1'b0, 1'b1, 5'(i), 8'(i), lat, rd);
      if (lat != 3) badLat++;
    end
    chk("wrap_lat", badLat, 32'd0);
    chk("wrap_256", {24'd0, b2.wr_count}, 32'h00);
    txn(1'b0, 1'b1, 5'd0, 8'h5A, lat, rd);
    chk("wrap_257", {24'd0, b2.wr_count}, 32'h01);
    txn(1'b0, 1'b0, 5'd31, 8'h00, lat, rd);
    chk("wrap_read31", {24'd0, rd}, 32'hFF);
    txn(1'b0, 1'b0, 5'd0, 8'h00, lat, rd);
    chk("wrap_read0", {24'd0, rd}, 32'h5A);

    // Zero-wait instance.
    txn(1'b1, 1'b1, 5'd4, 8'h77, lat, rd);
    chk("ws0_wlat", lat, 32'd1);
    chk("ws0_wrcnt", {24'd0, b0.wr_count}, 32'd1);
    txn(1'b1, 1'b0, 5'd4, 8'h00, lat, rd);
    chk("ws0_rlat", lat, 32'd1);
    chk("ws0_rdata", {24'd0, rd}, 32'h77);
    setReq(1'b1, 1'b1, 1'b1, 5'd6, 8'hEE);
    step();
    chk("ws0_ack_direct", {31'd0, b0.ack}, 32'd1);
    rst = 1'b1;
    b0.req = 1'b0;
    step();
    rst = 1'b0;
    chk("ws0_rst_ack", {31'd0, b0.ack}, 32'd0);
    chk("ws0_rst_busy", {31'd0, b0.busy}, 32'd0);
    txn(1'b1, 1'b0, 5'd6, 8'h00, lat, rd);
    chk("ws0_read6", {24'd0, rd}, 32'h00);
    chk("ws0_wrcnt0", {24'd0, b0.wr_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
